seg_scan_mux: RTL and testbench
===============================

// Module: seg_scan_mux
// PURPOSE
//  Downstream consumer of the timer digit counters. Takes NUM_DIGITS packed 4-bit digit values
//  (display_time_digit outputs of the chained timers) and time-multiplexes them onto one
//  common-anode seven-segment display. Provides per-frame snapshotting, optional leading-zero
//  blanking and anti-ghosting dead time between digit slots.
// PARAMETERS
//  NUM_DIGITS   4      number of digits scanned (>=2)
//  REFRESH_DIV  50000  clk cycles per digit slot (> DEAD_CYCLES+1)
//  DEAD_CYCLES  16     cycles at the start of each slot with all anodes off (>=1)
// PORTS
//  clk         in   1             system clock, rising edge
//  rst         in   1             asynchronous reset, active low
//  digits_in   in   4*NUM_DIGITS  digit i at [4*i+3:4*i]; digit 0 = least significant/rightmost
//  dp_in       in   NUM_DIGITS    decimal point request per digit, 1 = lit
//  blank_lz    in   1             1 = blank leading zeros
//  seg_n       out  7             segments {g,f,e,d,c,b,a}, active low
//  dp_n        out  1             decimal point, active low
//  an_n        out  NUM_DIGITS    anode select, active low, at most one low at any time
//  frame_start out  1             1-cycle pulse when a new frame snapshot is taken
// BEHAVIOUR
//  - Reset (async, rst=0): seg_n=7'h7F, dp_n=1, an_n=all 1, frame_start=0, slot counter=0,
//    digit index=NUM_DIGITS-1, shadow regs=0, FSM=BLANK. Outputs go inactive immediately
//    on rst falling edge, mid-slot included.
//  - Slot counter: 0..REFRESH_DIV-1, wraps to 0; at wrap, index decrements
//    (NUM_DIGITS-1 -> ... -> 0 -> NUM_DIGITS-1 wrap).
//  - FSM per slot: BLANK for counter 0..DEAD_CYCLES-1 (an_n all 1, seg_n 7'h7F, dp_n 1),
//    then DRIVE for remaining REFRESH_DIV-DEAD_CYCLES cycles (an_n[idx]=0 unless blanked).
//    Anode changes therefore always separated by DEAD_CYCLES all-off cycles.
//  - Snapshot: at first cycle of slot for idx=NUM_DIGITS-1 (incl. first slot after reset),
//    digits_in, dp_in, blank_lz latched into shadow regs; frame_start=1 that cycle only.
//    Input changes mid-frame invisible until next snapshot.
//  - Decode from shadow: 0-9 standard glyphs, A-F hex glyphs (A,b,C,d,E,F).
//    Examples: 0->7'b1000000, 4->7'b0011001, 7->7'b1111000.
//  - Leading-zero blank (shadow blank_lz=1): digit i>0 blanked iff it and all higher digits
//    are 0; digit 0 never blanked. Blanked slot behaves as BLANK for whole slot (dp also off).
//  - Outputs registered: seg_n/dp_n/an_n reflect FSM/counter state with 1-cycle latency,
//    identical for all digits.
//  - No enable input; scanning free-runs out of reset.
// STRUCTURE
//  - Package seg_pkg: SEG_OFF=7'h7F, glyph localparams for 0-F, clog2-based IDX_W helper.
//  - Sub-module bcd_to_7seg (4-bit in -> 7-bit active-low pattern, purely combinational),
//    instantiated once on the selected shadow digit.
//  - Top: slot counter, index counter, 2-state FSM, shadow regs, LZ mask, output regs.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2)
//  1. Assert rst mid-DRIVE -> same cycle: an_n=4'hF, seg_n=7'h7F, dp_n=1; after release,
//     first frame_start on first clock.
//  2. digits_in=16'h1234, blank_lz=0 -> an_n 0111 '1' (7'b1111001), 1011 '2', 1101 '3',
//     1110 '4' (7'b0011001); each 6 cycles low, 2 all-high between.
//  3. Change digits_in 16'h1234->16'h5678 during idx=2 slot -> remaining slots still show 3,4;
//     5678 appears only after next frame_start.
//  4. blank_lz=1, digits_in=16'h0070 -> digits 3,2 dark, digit1 '7' (7'b1111000), digit0 '0';
//     16'h0000 -> only digit0 lit with '0'.
//  5. digits_in=16'hAF0B, dp_in=4'b0100 -> hex glyphs A,F,0,b; dp_n=0 only while an_n=1011.
//  6. Run 10 frames with random inputs -> never more than one an_n bit low;
//     frame_start period exactly 32 cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, glyph table and helpers for the seven-segment scanner
package seg_pkg;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef enum logic {BLANK, DRIVE} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: hex digit to active-low {g,f,e,d,c,b,a} segment pattern
module bcd_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] d,
  output logic [6:0] seg
);
  assign seg = GLYPH[d];
endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed common-anode display driver with snapshot, LZ blanking and dead time
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_start
);
  localparam int IW = idx_w(NUM_DIGITS);
  localparam int CW = idx_w(REFRESH_DIV);
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  state_t state;
  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0] sh_dp;
  logic sh_lz;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic lead;
  logic slot_end;
  logic frame_first;
  logic lit;
  logic [6:0] glyph;
  assign slot_end    = cnt == CW'(REFRESH_DIV - 1);
  assign frame_first = (cnt == '0) && (idx == IW'(NUM_DIGITS - 1));
  assign lit         = (state == DRIVE) && !lz_mask[idx];
  bcd_to_7seg u_dec (
    .d   (sh_digits[4*idx +: 4]),
    .seg (glyph)
  );
  // a digit is a leading zero when it and every higher digit of the snapshot are zero
  always_comb begin
    lz_mask = '0;
    lead = sh_lz;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lead = lead && (sh_digits[4*i +: 4] == 4'd0);
      lz_mask[i] = lead;
    end
  end
  // slot/digit counters, dead-time FSM and per-frame snapshot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      idx         <= IW'(NUM_DIGITS - 1);
      state       <= BLANK;
      frame_start <= 1'b0;
      sh_digits   <= '0;
      sh_dp       <= '0;
      sh_lz       <= 1'b0;
    end else begin
      cnt         <= slot_end ? '0 : cnt + 1'b1;
      idx         <= !slot_end ? idx : (idx == '0) ? IW'(NUM_DIGITS - 1) : idx - 1'b1;
      state       <= slot_end ? BLANK : (cnt == CW'(DEAD_CYCLES - 1)) ? DRIVE : state;
      frame_start <= frame_first;
      sh_digits   <= frame_first ? digits_in : sh_digits;
      sh_dp       <= frame_first ? dp_in : sh_dp;
      sh_lz       <= frame_first ? blank_lz : sh_lz;
    end
  end
  // registered display outputs, all dark during dead time and for blanked digits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_n <= SEG_OFF;
      dp_n  <= 1'b1;
      an_n  <= '1;
    end else begin
      seg_n <= lit ? glyph : SEG_OFF;
      dp_n  <= !(lit && sh_dp[idx]);
      an_n  <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
    end
  end
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: vector table plus scoreboard check of the digit scanner
module tb_seg_scan_mux;
  localparam int N = 4;
  localparam int R = 8;
  localparam int D = 2;
  typedef struct {
    logic [15:0] d;
    logic [3:0]  dp;
    logic        blz;
    logic [27:0] seg;
    logic [3:0]  lit;
  } vec_t;
  typedef logic [11:0] slot_t;
  localparam slot_t OFF = {4'hF, 7'h7F, 1'b1};
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0] dp_in = '0;
  logic blank_lz = 1'b0;
  logic [6:0] seg_n;
  logic dp_n;
  logic [3:0] an_n;
  logic frame_start;
  int compared = 0;
  int mismatched = 0;
  slot_t sb[$];
  vec_t vecs[10];

  always #5 clk = ~clk;

  seg_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .blank_lz    (blank_lz),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .an_n        (an_n),
    .frame_start (frame_start)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @%0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  task automatic drive_vec(input vec_t v);
    digits_in = v.d;
    dp_in = v.dp;
    blank_lz = v.blz;
  endtask

  task automatic push_vec(input vec_t v);
    for (int s = 0; s < N; s++) begin
      int i = N - 1 - s;
      if (v.lit[i]) sb.push_back({~(4'b0001 << i), v.seg[7*i +: 7], ~v.dp[i]});
      else sb.push_back(OFF);
    end
  endtask

  task automatic wait_fs(output bit found);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      found = frame_start;
    end
    if (!found) begin
      compared++;
      mismatched++;
      $display("FAIL frame_start_timeout @%0t: got none, want pulse within 40 cycles", $time);
    end
  endtask

  task automatic check_frame(input bit synced, input bit chg, input int chg_t, input logic [15:0] chg_d);
    slot_t e[4];
    bit found;
    if (sb.size() < 4) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_underflow: got %0d entries, want 4", sb.size());
      return;
    end
    for (int s = 0; s < 4; s++) e[s] = sb.pop_front();
    found = synced;
    if (!found) wait_fs(found);
    if (!found) return;
    for (int t = 0; t < N * R; t++) begin
      if (t > 0) @(negedge clk);
      chk("frame_start", frame_start, t == 0);
      chk("slot", {an_n, seg_n, dp_n}, (t % R < D) ? OFF : e[t / R]);
      if (chg && t == chg_t) digits_in = chg_d;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    bit found;
    int last;
    int viol;
    int nfs;
    vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
    vecs[1] = '{16'h0070, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b0011};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0001};
    vecs[3] = '{16'hAF0B, 4'b0100, 1'b0, {7'h08, 7'h0E, 7'h40, 7'h03}, 4'b1111};
    vecs[4] = '{16'h0070, 4'b1111, 1'b0, {7'h40, 7'h40, 7'h78, 7'h40}, 4'b1111};
    vecs[5] = '{16'h0305, 4'b0000, 1'b1, {7'h7F, 7'h30, 7'h40, 7'h12}, 4'b0111};
    vecs[6] = '{16'h0000, 4'b1111, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0001};
    vecs[7] = '{16'h89CE, 4'b1010, 1'b0, {7'h00, 7'h10, 7'h46, 7'h06}, 4'b1111};
    vecs[8] = '{16'hD56F, 4'b0001, 1'b0, {7'h21, 7'h12, 7'h02, 7'h0E}, 4'b1111};
    vecs[9] = '{16'h5678, 4'b0000, 1'b0, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b1111};
    drive_vec(vecs[0]);
    repeat (3) @(negedge clk);
    chk("reset_outputs", {an_n, seg_n, dp_n}, OFF);
    chk("reset_frame_start", frame_start, 0);
    rst = 1'b1;
    push_vec(vecs[0]);
    @(negedge clk);
    chk("first_frame_start", frame_start, 1);
    check_frame(1'b1, 1'b0, 0, '0);
    for (int i = 1; i < 9; i++) begin
      drive_vec(vecs[i]);
      push_vec(vecs[i]);
      check_frame(1'b0, 1'b0, 0, '0);
    end
    drive_vec(vecs[0]);
    push_vec(vecs[0]);
    check_frame(1'b0, 1'b1, 10, 16'h5678);
    push_vec(vecs[9]);
    check_frame(1'b0, 1'b0, 0, '0);
    drive_vec(vecs[0]);
    wait_fs(found);
    repeat (4) @(negedge clk);
    chk("pre_reset_anode", an_n, 4'b0111);
    #2 rst = 1'b0;
    #1 chk("async_reset_outputs", {an_n, seg_n, dp_n}, OFF);
    chk("async_reset_frame_start", frame_start, 0);
    @(negedge clk);
    drive_vec(vecs[3]);
    rst = 1'b1;
    push_vec(vecs[3]);
    @(negedge clk);
    chk("restart_frame_start", frame_start, 1);
    check_frame(1'b1, 1'b0, 0, '0);
    wait_fs(found);
    last = 0;
    viol = 0;
    nfs = 0;
    for (int c = 1; c <= 10 * N * R; c++) begin
      @(negedge clk);
      digits_in = 16'($urandom);
      dp_in = 4'($urandom);
      blank_lz = 1'($urandom);
      if ($countones(~an_n) > 1) viol++;
      if (frame_start) begin
        chk("frame_period", c - last, N * R);
        last = c;
        nfs++;
      end
    end
    chk("anode_onehot_violations", viol, 0);
    chk("frame_count", nfs, 10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
